com_bus_arbiter: RTL and testbench
==================================

# com_bus_arbiter

Common-bus arbiter and invalidation collector for the 4-core MESI system. It sits on the shared bus opposite the per-core cache wrappers. It answers each cache's `Com_Bus_Req_proc` / `Com_Bus_Req_snoop` with the matching grant, and folds the per-core `Invalidation_done` lines into the single `All_Invalidation_done` handed back to the bus owner. A watchdog flags any grant held too long.

## Interface
- `NUM_CORES`, 4: caches on the common bus; RTL supports exactly 4.
- `TIMEOUT`, 255: maximum cycles a grant may be held before `Bus_timeout` is raised (8-bit counter).

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Com_Bus_Req_proc` in 4: processor-side bus requests, bit i = core i.
- `Com_Bus_Req_snoop` in 4: snoop-side (flush/write-back) bus requests.
- `Invalidate` in 1: common-bus invalidate line.
- `Invalidation_done` in 4: per-core invalidation acknowledge.
- `Com_Bus_Gnt_proc` out 4: one-hot-or-zero processor grant.
- `Com_Bus_Gnt_snoop` out 4: one-hot-or-zero snoop grant.
- `All_Invalidation_done` out 1: every non-owner core has acknowledged the current invalidate.
- `Bus_owner` out 2: index of the current proc owner; valid while `Bus_busy`.
- `Bus_busy` out 1: a proc or snoop grant is active.
- `Bus_timeout` out 1: sticky error, cleared only by reset.

## Operation
- States: IDLE, PROC, PROC_SNOOP, SNOOP.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer `last` = 3, so core 0 wins first.
  - Invalidation accumulator 0; timeout counter 0.
- **IDLE**
  - If any snoop request is set, grant the lowest-index snooper and go to SNOOP. Snoop has priority over proc.
  - Otherwise, if any proc request is set, grant the round-robin winner and go to PROC. The search starts at `(last+1) mod 4`; set `last` = winner.
- **PROC** (owner o)
  - A snoop request from core j≠o grants the lowest-index such j and goes to PROC_SNOOP. The proc grant stays asserted.
  - A snoop request from core o is ignored.
  - If `Com_Bus_Req_proc[o]` is sampled low, drop the grant and go to IDLE.
- **PROC_SNOOP**: when `Com_Bus_Req_snoop[j]` is sampled low, drop the snoop grant and return to PROC.
- **SNOOP**: when the request is sampled low, drop the grant and go to IDLE.
- **Owner drops request in PROC_SNOOP**: the proc grant is dropped immediately and the state goes to SNOOP. The flush in progress completes.
- **Invalidation**
  - While in PROC or PROC_SNOOP with `Invalidate` = 1, OR `Invalidation_done & ~(1<<o)` into a 4-bit accumulator.
  - `All_Invalidation_done` is registered. It is 1 when the accumulator (including the current sample) covers all three non-owner bits.
  - It stays 1 while `Invalidate` = 1.
  - Accumulator and output clear when `Invalidate` = 0 or the proc grant drops.
  - The owner's own done bit is ignored.
- **Watchdog**
  - The counter increments each cycle `Bus_busy` = 1 and resets to 0 on any grant change.
  - Reaching `TIMEOUT` sets `Bus_timeout`. The counter saturates.
  - Grants are not revoked on timeout.
- Simultaneous release and new request: release wins that cycle. The new request is arbitrated from IDLE next cycle.

## Timing
- Grant latency: a request sampled at edge n gives a grant visible after edge n+1 (1 cycle, registered).
- Release: request low sampled at edge n gives the grant low after edge n+1.
- Between consecutive proc owners there is exactly one IDLE cycle. Min turnaround: req-low to next grant = 2 cycles.
- Snoop grant inside PROC: 1 cycle after the snoop request is sampled.
- `All_Invalidation_done`: 1 cycle after the last required done bit is sampled. It falls 1 cycle after `Invalidate` falls.
- Async reset mid-transaction: all grants and `All_Invalidation_done` deassert immediately on `rst_n` low. State returns to IDLE with `last` = 3.

## Structure
- Shared package `com_bus_def` holds:
  - the state encoding (IDLE=0, PROC=1, PROC_SNOOP=2, SNOOP=3);
  - `NUM_CORES`;
  - the core-index width constant.
- One sub-module, `rr_pick4`: combinational 4-way round-robin picker taking the request vector and `last`, returning the winner index and a valid flag.
- The FSM, accumulator and watchdog live in the top.

## Test plan
- **Reset then simultaneous requests:** `Com_Bus_Req_proc`=4'b1111 → `Com_Bus_Gnt_proc` goes 0001, 0010, 0100, 1000 in turn as each holder drops its request, with 1 IDLE cycle between owners.
- **Nested snoop:** core 2 owns the bus and core 0 raises snoop req → `Com_Bus_Gnt_snoop`=0001 one cycle later while `Com_Bus_Gnt_proc`=0100 is held. Snoop release returns to PROC.
- **Snoop priority:** in IDLE, proc req 0010 and snoop req 1000 arrive the same cycle → `Com_Bus_Gnt_snoop`=1000 first. The proc grant follows after release + IDLE.
- **Invalidation:** owner 1, `Invalidate`=1; `Invalidation_done` 0001, then 0100, then 1010 on separate cycles → `All_Invalidation_done`=1 one cycle after the third. It is not asserted earlier even though bit 1 was high.
- **Watchdog:** `TIMEOUT`=8, a proc request is held 20 cycles → `Bus_timeout`=1 after 8 busy cycles and stays 1 after release.
- **Reset mid-invalidate:** `rst_n` pulsed low during PROC_SNOOP with `All_Invalidation_done`=1 → all outputs 0 asynchronously. The next grant after reset goes to core 0.

Source files
------------

// File: rtl/com_bus_arbiter_pkg.sv
// Shared definitions for the common-bus arbiter: core count, index width,
// FSM state encoding and small one-hot helpers.
package com_bus_def;
  localparam int NUM_CORES = 4;
  localparam int CORE_W    = 2;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PROC       = 2'd1;
  localparam logic [1:0] ST_PROC_SNOOP = 2'd2;
  localparam logic [1:0] ST_SNOOP      = 2'd3;

  typedef logic [CORE_W-1:0]    core_idx_t;
  typedef logic [NUM_CORES-1:0] core_vec_t;

  function automatic core_vec_t core_onehot(input core_idx_t i);
    core_onehot    = '0;
    core_onehot[i] = 1'b1;
  endfunction

  // Fixed-priority pick: lowest set bit wins.
  function automatic core_idx_t lowest_core(input core_vec_t v);
    lowest_core = '0;
    for (int k = NUM_CORES-1; k >= 0; k--)
      if (v[k]) lowest_core = core_idx_t'(k);
  endfunction
endpackage

// File: rtl/com_bus_arbiter_if.sv
// Common-bus request/grant bundle between the cache wrappers (master) and
// the arbiter (slave).
interface com_bus_arbiter_if import com_bus_def::*; ();
  core_vec_t Com_Bus_Req_proc;
  core_vec_t Com_Bus_Req_snoop;
  logic      Invalidate;
  core_vec_t Invalidation_done;
  core_vec_t Com_Bus_Gnt_proc;
  core_vec_t Com_Bus_Gnt_snoop;
  logic      All_Invalidation_done;
  core_idx_t Bus_owner;
  logic      Bus_busy;
  logic      Bus_timeout;

  modport slave (
    input  Com_Bus_Req_proc, Com_Bus_Req_snoop, Invalidate, Invalidation_done,
    output Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, All_Invalidation_done,
           Bus_owner, Bus_busy, Bus_timeout
  );

  modport master (
    output Com_Bus_Req_proc, Com_Bus_Req_snoop, Invalidate, Invalidation_done,
    input  Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, All_Invalidation_done,
           Bus_owner, Bus_busy, Bus_timeout
  );
endinterface

// File: rtl/com_bus_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker: searches from last+1 upward,
// wrapping, and returns the first requester.
module rr_pick4 import com_bus_def::*; (
  input  core_vec_t req_i,
  input  core_idx_t last_i,
  output core_idx_t idx_o,
  output logic      vld_o
);
  core_idx_t cand;

  always_comb begin
    idx_o = last_i;
    vld_o = 1'b0;
    cand  = '0;
    // Index arithmetic wraps naturally in CORE_W bits; k == NUM_CORES lands on last itself.
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = last_i + core_idx_t'(k);
      if (!vld_o && req_i[cand]) begin
        idx_o = cand;
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter: proc/snoop grant FSM, invalidation-ack collector and
// grant-hold watchdog for the 4-core MESI bus.
module com_bus_arbiter import com_bus_def::*; #(
  parameter int NUM_CORES = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  com_bus_arbiter_if.slave bus
);
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

  logic [1:0]           state_q, state_d;
  core_idx_t            last_q, last_d, owner_q, owner_d, snp_q, snp_d;
  logic [NUM_CORES-1:0] gnt_p_q, gnt_p_d, gnt_s_q, gnt_s_d;
  logic [NUM_CORES-1:0] acc_q, acc_d;
  logic                 alld_q, alld_d;
  logic [7:0]           wd_q, wd_d;
  logic                 to_q, to_d;

  core_vec_t req_p, req_s, own_mask, snp_other;
  core_idx_t rr_idx;
  logic      rr_vld, inv_hold, grant_chg, busy;

  assign req_p     = bus.Com_Bus_Req_proc;
  assign req_s     = bus.Com_Bus_Req_snoop;
  assign own_mask  = core_onehot(owner_q);
  assign snp_other = req_s & ~own_mask;

  rr_pick4 u_rr (
    .req_i  (req_p),
    .last_i (last_q),
    .idx_o  (rr_idx),
    .vld_o  (rr_vld)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    snp_d   = snp_q;
    gnt_p_d = gnt_p_q;
    gnt_s_d = gnt_s_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_s) begin
          snp_d   = lowest_core(req_s);
          gnt_s_d = core_onehot(lowest_core(req_s));
          state_d = ST_SNOOP;
        end else if (rr_vld) begin
          owner_d = rr_idx;
          last_d  = rr_idx;
          gnt_p_d = core_onehot(rr_idx);
          state_d = ST_PROC;
        end
      end
      ST_PROC: begin
        // Owner release beats a concurrent snoop request.
        if (!req_p[owner_q]) begin
          gnt_p_d = '0;
          state_d = ST_IDLE;
        end else if (|snp_other) begin
          snp_d   = lowest_core(snp_other);
          gnt_s_d = core_onehot(lowest_core(snp_other));
          state_d = ST_PROC_SNOOP;
        end
      end
      ST_PROC_SNOOP: begin
        if (!req_p[owner_q]) gnt_p_d = '0;
        if (!req_s[snp_q])   gnt_s_d = '0;
        case ({req_p[owner_q], req_s[snp_q]})
          2'b11:   state_d = ST_PROC_SNOOP;
          2'b10:   state_d = ST_PROC;
          2'b01:   state_d = ST_SNOOP;
          default: state_d = ST_IDLE;
        endcase
      end
      ST_SNOOP: begin
        if (!req_s[snp_q]) begin
          gnt_s_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Collection only runs while a proc owner holds the bus and keeps it this cycle.
  always_comb begin
    inv_hold = (|gnt_p_q) && (|gnt_p_d) && bus.Invalidate;
    acc_d    = inv_hold ? (acc_q | (bus.Invalidation_done & ~own_mask)) : '0;
    alld_d   = inv_hold && ((acc_d | own_mask) == '1);
  end

  always_comb begin
    busy      = (|gnt_p_q) || (|gnt_s_q);
    grant_chg = (gnt_p_d != gnt_p_q) || (gnt_s_d != gnt_s_q);
    if (grant_chg)                    wd_d = '0;
    else if (busy && wd_q != WD_LIMIT) wd_d = wd_q + 8'd1;
    else                              wd_d = wd_q;
    to_d = to_q || (wd_d == WD_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= core_idx_t'(NUM_CORES-1);
      owner_q <= '0;
      snp_q   <= '0;
      gnt_p_q <= '0;
      gnt_s_q <= '0;
      acc_q   <= '0;
      alld_q  <= 1'b0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      snp_q   <= snp_d;
      gnt_p_q <= gnt_p_d;
      gnt_s_q <= gnt_s_d;
      acc_q   <= acc_d;
      alld_q  <= alld_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  assign bus.Com_Bus_Gnt_proc      = gnt_p_q;
  assign bus.Com_Bus_Gnt_snoop     = gnt_s_q;
  assign bus.All_Invalidation_done = alld_q;
  assign bus.Bus_owner             = owner_q;
  assign bus.Bus_busy              = busy;
  assign bus.Bus_timeout           = to_q;
endmodule

// File: tb/tb_com_bus_arbiter.sv
// Randomized + directed bench for com_bus_arbiter against a holder-based
// behavioural model (who holds proc/snoop, not FSM states).
module tb_com_bus_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  com_bus_arbiter_if bus();

  com_bus_arbiter #(.NUM_CORES(4), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: -1 means nobody holds that grant.
  int         m_po, m_sn, m_last, m_cnt;
  logic [3:0] m_acc;
  logic       m_alld, m_to;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    lowest = -1;
    for (int k = 3; k >= 0; k--) if (v[k]) lowest = k;
  endfunction

  function automatic logic [3:0] oh(input int i);
    oh = (i < 0) ? 4'b0000 : (4'b0001 << i);
  endfunction

  always @(posedge clk or negedge rst_n) begin : ref_model
    int         npo, nsn, c;
    logic [3:0] rp, rs, own;
    if (!rst_n) begin
      m_po = -1; m_sn = -1; m_last = 3; m_acc = 0; m_alld = 0; m_cnt = 0; m_to = 0;
    end else begin
      rp = bus.Com_Bus_Req_proc;
      rs = bus.Com_Bus_Req_snoop;
      npo = m_po;
      nsn = m_sn;
      if (m_po < 0 && m_sn < 0) begin
        if (rs != 0) nsn = lowest(rs);
        else if (rp != 0) begin
          for (int k = 1; k <= 4; k++) begin
            c = (m_last + k) % 4;
            if (npo < 0 && rp[c]) npo = c;
          end
          m_last = npo;
        end
      end else begin
        if (m_po >= 0 && !rp[m_po]) npo = -1;
        if (m_sn >= 0) begin
          if (!rs[m_sn]) nsn = -1;
        end else if (npo >= 0) begin
          own = oh(m_po);
          if ((rs & ~own) != 0) nsn = lowest(rs & ~own);
        end
      end
      if (m_po >= 0 && npo >= 0 && bus.Invalidate) begin
        own    = oh(m_po);
        m_acc  = m_acc | (bus.Invalidation_done & ~own);
        m_alld = ((m_acc | own) == 4'hf);
      end else begin
        m_acc  = 0;
        m_alld = 0;
      end
      if (npo != m_po || nsn != m_sn) m_cnt = 0;
      else if ((m_po >= 0 || m_sn >= 0) && m_cnt < TO) m_cnt++;
      if (m_cnt == TO) m_to = 1;
      m_po = npo;
      m_sn = nsn;
    end
  end

  task automatic check_all();
    chk("gnt_proc", 32'(bus.Com_Bus_Gnt_proc), 32'(oh(m_po)));
    chk("gnt_snoop", 32'(bus.Com_Bus_Gnt_snoop), 32'(oh(m_sn)));
    chk("all_inv_done", 32'(bus.All_Invalidation_done), 32'(m_alld));
    chk("busy", 32'(bus.Bus_busy), 32'(m_po >= 0 || m_sn >= 0));
    chk("timeout", 32'(bus.Bus_timeout), 32'(m_to));
    if (m_po >= 0) chk("owner", 32'(bus.Bus_owner), 32'(m_po));
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  task automatic drv(input logic [3:0] rp, input logic [3:0] rs, input logic inv, input logic [3:0] dn);
    bus.Com_Bus_Req_proc  = rp;
    bus.Com_Bus_Req_snoop = rs;
    bus.Invalidate        = inv;
    bus.Invalidation_done = dn;
  endtask

  task automatic wait_idle();
    drv(0, 0, 0, 0);
    for (int k = 0; k < 20 && (m_po >= 0 || m_sn >= 0); k++) tick();
    tick();
    chk("idle_wait", 32'(bus.Bus_busy), 32'd0);
  endtask

  int         order[$];
  int         prev, held;
  logic [3:0] dropped, r_p, r_s;
  int         hp[4], lim[4], sh[4], slim[4];

  initial begin
    drv(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_gnt_proc", 32'(bus.Com_Bus_Gnt_proc), 32'd0);
    chk("rst_busy", 32'(bus.Bus_busy), 32'd0);
    rst_n = 1'b1;

    // All four request at once; each drops after two granted cycles.
    prev = -1; held = 0; dropped = 0;
    for (int c = 0; c < 30; c++) begin
      drv(4'hf & ~dropped, 0, 0, 0);
      tick();
      if (m_po >= 0) begin
        if (m_po != prev) begin order.push_back(m_po); prev = m_po; held = 0; end
        held++;
        if (held >= 2) dropped |= oh(m_po);
      end
    end
    chk("rr_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'(i));
    wait_idle();

    // Nested snoop under owner 2; the owner's own snoop is ignored.
    drv(4'b0100, 0, 0, 0);       tick();
    chk("nest_own", 32'(bus.Com_Bus_Gnt_proc), 32'h4);
    drv(4'b0100, 4'b0100, 0, 0); tick();
    chk("own_snp_ign", 32'(bus.Com_Bus_Gnt_snoop), 32'h0);
    drv(4'b0100, 4'b0001, 0, 0); tick();
    chk("nest_snp", 32'(bus.Com_Bus_Gnt_snoop), 32'h1);
    chk("nest_hold", 32'(bus.Com_Bus_Gnt_proc), 32'h4);
    drv(4'b0100, 0, 0, 0);       tick();
    chk("nest_rel", 32'(bus.Com_Bus_Gnt_snoop), 32'h0);
    chk("nest_back", 32'(bus.Com_Bus_Gnt_proc), 32'h4);
    wait_idle();

    // Snoop beats proc from IDLE.
    drv(4'b0010, 4'b1000, 0, 0); tick();
    chk("snp_pri", 32'(bus.Com_Bus_Gnt_snoop), 32'h8);
    chk("snp_pri_p", 32'(bus.Com_Bus_Gnt_proc), 32'h0);
    drv(4'b0010, 0, 0, 0);       tick();
    chk("snp_pri_idle", 32'(bus.Bus_busy), 32'd0);
    tick();
    chk("snp_pri_then", 32'(bus.Com_Bus_Gnt_proc), 32'h2);

    // Invalidation collection with owner 1.
    drv(4'b0010, 0, 1, 4'b0001); tick();
    chk("inv_1", 32'(bus.All_Invalidation_done), 32'd0);
    drv(4'b0010, 0, 1, 4'b0100); tick();
    chk("inv_2", 32'(bus.All_Invalidation_done), 32'd0);
    drv(4'b0010, 0, 1, 4'b1010); tick();
    chk("inv_all", 32'(bus.All_Invalidation_done), 32'd1);
    drv(4'b0010, 0, 1, 4'b0000); tick();
    chk("inv_hold", 32'(bus.All_Invalidation_done), 32'd1);
    drv(4'b0010, 0, 0, 4'b0000); tick();
    chk("inv_fall", 32'(bus.All_Invalidation_done), 32'd0);
    wait_idle();

    // Cache-like random traffic.
    r_p = 0; r_s = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (r_p[i]) begin
          if (m_po == i) begin hp[i]++; if (hp[i] >= lim[i]) r_p[i] = 1'b0; end
        end else if ($urandom_range(0, 3) == 0) begin
          r_p[i] = 1'b1; hp[i] = 0; lim[i] = $urandom_range(1, 12);
        end
        if (r_s[i]) begin
          if (m_sn == i) begin sh[i]++; if (sh[i] >= slim[i]) r_s[i] = 1'b0; end
        end else if ($urandom_range(0, 11) == 0) begin
          r_s[i] = 1'b1; sh[i] = 0; slim[i] = $urandom_range(1, 4);
        end
      end
      drv(r_p, r_s, ($urandom_range(0, 3) != 0), 4'($urandom));
    end
    wait_idle();

    // Watchdog from a clean reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drv(4'b0001, 0, 0, 0); tick();
    chk("wd_gnt", 32'(bus.Com_Bus_Gnt_proc), 32'h1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 7) chk("to_early", 32'(bus.Bus_timeout), 32'd0);
      if (k == 8) chk("to_set", 32'(bus.Bus_timeout), 32'd1);
    end
    drv(0, 0, 0, 0); tick(); tick();
    chk("to_sticky", 32'(bus.Bus_timeout), 32'd1);
    chk("to_grant_kept", 32'(bus.Com_Bus_Gnt_proc), 32'h0);

    // Reset during PROC_SNOOP with invalidation complete.
    drv(4'b0100, 0, 0, 0);             tick();
    drv(4'b0100, 4'b0001, 1, 4'b1011); tick();
    chk("rst_pre_alld", 32'(bus.All_Invalidation_done), 32'd1);
    chk("rst_pre_snp", 32'(bus.Com_Bus_Gnt_snoop), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt_p", 32'(bus.Com_Bus_Gnt_proc), 32'h0);
    chk("arst_gnt_s", 32'(bus.Com_Bus_Gnt_snoop), 32'h0);
    chk("arst_alld", 32'(bus.All_Invalidation_done), 32'd0);
    chk("arst_busy", 32'(bus.Bus_busy), 32'd0);
    chk("arst_to", 32'(bus.Bus_timeout), 32'd0);
    @(negedge clk);
    drv(4'hf, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_core0", 32'(bus.Com_Bus_Gnt_proc), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
